// File: rtl/alu_pkg.sv
// Shared ALU-pipe types: field widths, the issue-queue entry layout,
// and small helpers used by dispatch and the issue queues.
package alu_pkg;

    localparam int OP_W  = 5;
    localparam int TAG_W = 6;
    localparam int ROB_W = 6;
    localparam int IMM_W = 20;

    typedef struct packed {
        logic             vld;
        logic [OP_W-1:0]  op;
        logic [IMM_W-1:0] imm;
        logic [TAG_W-1:0] dest;
        logic [TAG_W-1:0] src1;
        logic [TAG_W-1:0] src2;
        logic             rdy1;
        logic             rdy2;
        logic [ROB_W-1:0] rob_id;
    } iq_entry_t;

    // Opcodes that take an immediate in place of source 2; dispatch forces src2_rdy for these.
    function automatic logic is_imm_op(input logic [OP_W-1:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
            5'd21, 5'd22, 5'd23: is_imm_op = 1'b1;
            default:             is_imm_op = 1'b0;
        endcase
    endfunction

    // True when a tag matches either result broadcast this cycle.
    function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                     input logic v0, input logic [TAG_W-1:0] t0,
                                     input logic v1, input logic [TAG_W-1:0] t1);
        tag_hit = (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

endpackage

// File: rtl/alu0_iq_select.sv
// Oldest-ready picker: one-hot grant on the lowest set request bit.
module alu0_iq_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o,
    output logic             found_o
);

    // Isolate the lowest set bit (two's-complement trick).
    assign grant_o = req_i & (~req_i + DEPTH'(1));
    assign found_o = |req_i;

endmodule

// File: rtl/alu0_issue_queue.sv
// ALU0 issue queue: collapsing, age-ordered (slot 0 oldest), with
// tag wakeup from ALU0/BRU and zero-cycle oldest-ready select.
module alu0_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_vld,
    output logic             disp_rdy,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [IMM_W-1:0] disp_imm,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic [TAG_W-1:0] disp_src1,
    input  logic [TAG_W-1:0] disp_src2,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [ROB_W-1:0] disp_ROB_ID,
    input  logic             ALU0_wake_vld,
    input  logic [TAG_W-1:0] ALU0_wake_tag,
    input  logic             BRU_wake_vld,
    input  logic [TAG_W-1:0] BRU_wake_tag,
    output logic             ALU0_select_vld,
    output logic [OP_W-1:0]  ALU0_select_op,
    output logic [IMM_W-1:0] ALU0_select_imm,
    output logic [TAG_W-1:0] ALU0_select_dest,
    output logic [TAG_W-1:0] ALU0_select_source1,
    output logic [TAG_W-1:0] ALU0_select_source2,
    output logic [ROB_W-1:0] ALU0_select_ROB_ID,
    output logic [CNT_W-1:0] iq_count
);

    iq_entry_t        ent_q [DEPTH];
    iq_entry_t        ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] ready, grant;
    logic             found, issue, accept;

    // An entry can issue once both operands are ready.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ready[i] = ent_q[i].vld & ent_q[i].rdy1 & ent_q[i].rdy2;
    end

    alu0_iq_select #(.DEPTH(DEPTH)) u_sel (
        .req_i   (ready),
        .grant_o (grant),
        .found_o (found)
    );

    // Flush suppresses issue; no recycle of a freed slot in the same cycle.
    assign issue    = found & ~flush;
    assign disp_rdy = (cnt_q < CNT_W'(DEPTH));
    assign accept   = disp_vld & disp_rdy;
    assign iq_count = cnt_q;

    // Drive the select bundle from the granted slot, all zero when nothing issues.
    always_comb begin
        ALU0_select_vld     = issue;
        ALU0_select_op      = '0;
        ALU0_select_imm     = '0;
        ALU0_select_dest    = '0;
        ALU0_select_source1 = '0;
        ALU0_select_source2 = '0;
        ALU0_select_ROB_ID  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && grant[i]) begin
                ALU0_select_op      = ent_q[i].op;
                ALU0_select_imm     = ent_q[i].imm;
                ALU0_select_dest    = ent_q[i].dest;
                ALU0_select_source1 = ent_q[i].src1;
                ALU0_select_source2 = ent_q[i].src2;
                ALU0_select_ROB_ID  = ent_q[i].rob_id;
            end
        end
    end

    // Collapse above the issued slot, apply wakeup, then append the dispatched entry.
    always_comb begin
        iq_entry_t        src;
        logic             shift;
        logic [CNT_W-1:0] wr_idx;
        src    = '0;
        shift  = 1'b0;
        wr_idx = cnt_q - CNT_W'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            // Once the issued slot is passed, every slot takes its upper neighbour.
            shift = shift | (issue & grant[i]);
            if (shift)
                src = (i == DEPTH-1) ? '0 : ent_q[(i+1) % DEPTH];
            else
                src = ent_q[i];
            if (src.vld) begin
                src.rdy1 = src.rdy1 | tag_hit(src.src1, ALU0_wake_vld, ALU0_wake_tag,
                                              BRU_wake_vld, BRU_wake_tag);
                src.rdy2 = src.rdy2 | tag_hit(src.src2, ALU0_wake_vld, ALU0_wake_tag,
                                              BRU_wake_vld, BRU_wake_tag);
            end
            // Bypass same-cycle broadcasts into the new entry so no wakeup is lost.
            if (accept && (wr_idx == CNT_W'(i))) begin
                src.vld    = 1'b1;
                src.op     = disp_op;
                src.imm    = disp_imm;
                src.dest   = disp_dest;
                src.src1   = disp_src1;
                src.src2   = disp_src2;
                src.rdy1   = disp_src1_rdy | tag_hit(disp_src1, ALU0_wake_vld, ALU0_wake_tag,
                                                     BRU_wake_vld, BRU_wake_tag);
                src.rdy2   = disp_src2_rdy | tag_hit(disp_src2, ALU0_wake_vld, ALU0_wake_tag,
                                                     BRU_wake_vld, BRU_wake_tag);
                src.rob_id = disp_ROB_ID;
            end
            ent_d[i] = flush ? '0 : src;
        end
        cnt_d = flush ? '0 : (cnt_q + CNT_W'(accept) - CNT_W'(issue));
    end

    // Queue state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            cnt_q <= cnt_d;
        end
    end

endmodule
